canvas_grid_painter: RTL and testbench
======================================

CANVAS_GRID_PAINTER -- requirements
Module: canvas_grid_painter

Interface
REQ-001 Parameter X0, default 9'd89: left pixel column of the grid area.
REQ-002 Parameter Y0, default 9'd33: top pixel row of the grid area.
REQ-003 Parameters CELL_W and CELL_H, default 5 each: cell size in pixels, legal range 1..16.
REQ-004 Parameters GRID_W and GRID_H, default 28 each: cell counts, legal range 1..32.
REQ-005 Parameter COLOUR_BITS, default 15: pixel colour width.
REQ-006 Parameters DRAW_COLOUR, default all ones, and BG_COLOUR, default all zeros: paint and erase colours.
REQ-007 Ports: clock in 1, the single clock; reset in 1, synchronous and active-high.
REQ-008 Ports: mouse_x in 9 and mouse_y in 9, cursor pixel position.
REQ-009 Ports: left_click in 1, paint request; right_click in 1, erase-cell request; clear_all in 1, wipe-grid request.
REQ-010 Ports: vga_x out 9, vga_y out 9, vga_colour out COLOUR_BITS, vga_plot out 1: pixel write to the VGA adapter.
REQ-011 Ports: busy out 1, sequencer active; bitmap out GRID_W*GRID_H, cell occupancy with bit index row*GRID_W+col.

Function
REQ-012 States SHALL be IDLE, PAINT and CLEAR.
REQ-013 Cell coordinates SHALL be col=(mouse_x-X0)/CELL_W and row=(mouse_y-Y0)/CELL_H, computed combinationally; the cursor is in-grid only when X0<=mouse_x<X0+GRID_W*CELL_W and Y0<=mouse_y<Y0+GRID_H*CELL_H.
REQ-014 IDLE priority SHALL be clear_all, then left_click, then right_click; out-of-grid clicks are ignored.
REQ-015 A click accepted in cycle N SHALL latch col, row and colour (DRAW_COLOUR for left, BG_COLOUR for right) and enter PAINT at N+1.
REQ-016 PAINT SHALL emit exactly CELL_W*CELL_H plots, one per cycle, row-major from (X0+col*CELL_W, Y0+row*CELL_H), vga_plot=1 on each, and SHALL return to IDLE after the last plot.
REQ-017 The bitmap bit for the painted cell SHALL update (1 for paint, 0 for erase) on the clock edge ending the last PAINT plot.
REQ-018 CLEAR SHALL emit GRID_W*CELL_W*GRID_H*CELL_H plots of BG_COLOUR, row-major over the whole grid area, then clear the bitmap to all zeros and return to IDLE.
REQ-019 Clicks arriving while busy=1 SHALL be dropped, not queued.
REQ-020 clear_all asserted during PAINT SHALL set a pending flag; CLEAR SHALL start the cycle after PAINT ends, without revisiting IDLE decisions; clear_all during CLEAR SHALL be ignored.
REQ-021 busy SHALL equal 1 exactly in PAINT and CLEAR; vga_plot SHALL be 0 in IDLE, and vga_x, vga_y and vga_colour are don't-care whenever vga_plot=0.
REQ-022 A level-held click SHALL repaint the same cell each time IDLE is re-entered (no edge detection in this block).

Reset
REQ-023 While reset=1 at a clock edge: state=IDLE, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, bitmap=0, pending clear=0, all counters 0.
REQ-024 Reset asserted mid-PAINT or mid-CLEAR SHALL abort with no further plots and no bitmap update; pixels already drawn are not restored.

Configuration
REQ-025 Macro CANVAS_SKIP_REDUNDANT_EN: when defined, an IDLE click whose target bitmap bit already holds the requested value SHALL be ignored, so no PAINT occurs; when undefined, every accepted in-grid click paints.

Verification
REQ-026 Defaults, left_click=1 for 1 cycle at (89,33) -> 25 plots, x 89..93 and y 33..37 row-major, colour 7FFF, then bitmap[0]=1 and busy=0.
REQ-027 Left click at (228,172) -> plots x 224..228 and y 168..172, then bitmap[783]=1; left click at (88,33) or (229,40) -> no plot, busy stays 0.
REQ-028 Left and right clicks both high at (94,33) -> paint wins, bitmap[1]=1; a later right click there -> 25 plots of colour 0000, then bitmap[1]=0.
REQ-029 clear_all pulsed on the 3rd PAINT plot -> all 25 paint plots complete, then 19600 CLEAR plots, then bitmap=0 and busy=0.
REQ-030 Reset on the 10th PAINT plot -> vga_plot=0 and bitmap=0 from the next cycle; with CANVAS_SKIP_REDUNDANT_EN defined, a repeated left click on a set cell -> no plots.

Source files
------------

// File: rtl/canvas_grid_painter.sv
// Grid canvas painter: turns cursor clicks into per-pixel VGA writes for one cell or a full wipe.
// Optional feature macro: CANVAS_SKIP_REDUNDANT_EN (ignore clicks that would not change the bitmap).
module canvas_grid_painter #(
    parameter logic [8:0]             X0          = 9'd89,
    parameter logic [8:0]             Y0          = 9'd33,
    parameter int unsigned            CELL_W      = 5,
    parameter int unsigned            CELL_H      = 5,
    parameter int unsigned            GRID_W      = 28,
    parameter int unsigned            GRID_H      = 28,
    parameter int unsigned            COLOUR_BITS = 15,
    parameter logic [COLOUR_BITS-1:0] DRAW_COLOUR = '1,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR   = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [8:0]               mouse_x,
    input  logic [8:0]               mouse_y,
    input  logic                     left_click,
    input  logic                     right_click,
    input  logic                     clear_all,
    output logic [8:0]               vga_x,
    output logic [8:0]               vga_y,
    output logic [COLOUR_BITS-1:0]   vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic [GRID_W*GRID_H-1:0] bitmap
);

    localparam int unsigned AREA_W = GRID_W * CELL_W;
    localparam int unsigned AREA_H = GRID_H * CELL_H;
    localparam int unsigned NCELLS = GRID_W * GRID_H;
    localparam int unsigned CW_B   = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int unsigned CH_B   = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int unsigned COL_B  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned ROW_B  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int unsigned AX_B   = (AREA_W > 1) ? $clog2(AREA_W) : 1;
    localparam int unsigned AY_B   = (AREA_H > 1) ? $clog2(AREA_H) : 1;
    localparam int unsigned IDX_B  = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    localparam logic [10:0] X_END = 11'(X0) + 11'(AREA_W);
    localparam logic [10:0] Y_END = 11'(Y0) + 11'(AREA_H);

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        CLEAR
    } state_t;

    state_t                   state_q, state_n;
    logic [COL_B-1:0]         col_q, col_n;
    logic [ROW_B-1:0]         row_q, row_n;
    logic [COLOUR_BITS-1:0]   colour_q, colour_n;
    logic                     set_q, set_n;
    logic [CW_B-1:0]          px_q, px_n;
    logic [CH_B-1:0]          py_q, py_n;
    logic [AX_B-1:0]          cx_q, cx_n;
    logic [AY_B-1:0]          cy_q, cy_n;
    logic                     pend_q, pend_n;
    logic [NCELLS-1:0]        bitmap_n;

    // Cursor-to-cell mapping, widened so the upper grid bound cannot wrap.
    logic [10:0]              mx_w, my_w, dx, dy;
    logic                     in_grid;
    logic [COL_B-1:0]         cur_col;
    logic [ROW_B-1:0]         cur_row;
    logic [IDX_B-1:0]         cell_idx_q;
    logic                     accept;

    assign mx_w    = {2'b00, mouse_x};
    assign my_w    = {2'b00, mouse_y};
    assign dx      = mx_w - 11'(X0);
    assign dy      = my_w - 11'(Y0);
    assign in_grid = (mx_w >= 11'(X0)) && (mx_w < X_END) &&
                     (my_w >= 11'(Y0)) && (my_w < Y_END);
    assign cur_col = COL_B'(dx / 11'(CELL_W));
    assign cur_row = ROW_B'(dy / 11'(CELL_H));

    assign cell_idx_q = IDX_B'(32'(row_q) * GRID_W + 32'(col_q));

`ifdef CANVAS_SKIP_REDUNDANT_EN
    logic [IDX_B-1:0] cur_idx;
    assign cur_idx = IDX_B'(32'(cur_row) * GRID_W + 32'(cur_col));
    assign accept  = in_grid && (left_click || right_click) &&
                     (bitmap[cur_idx] != left_click);
`else
    assign accept  = in_grid && (left_click || right_click);
`endif

    always_comb begin
        state_n    = state_q;
        col_n      = col_q;
        row_n      = row_q;
        colour_n   = colour_q;
        set_n      = set_q;
        px_n       = px_q;
        py_n       = py_q;
        cx_n       = cx_q;
        cy_n       = cy_q;
        pend_n     = pend_q;
        bitmap_n   = bitmap;
        busy       = 1'b0;
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;

        case (state_q)
            IDLE: begin
                if (clear_all) begin
                    state_n = CLEAR;
                    cx_n    = '0;
                    cy_n    = '0;
                end else if (accept) begin
                    state_n  = PAINT;
                    col_n    = cur_col;
                    row_n    = cur_row;
                    set_n    = left_click;
                    colour_n = left_click ? DRAW_COLOUR : BG_COLOUR;
                    px_n     = '0;
                    py_n     = '0;
                end
            end

            PAINT: begin
                busy       = 1'b1;
                vga_plot   = 1'b1;
                vga_x      = 9'(32'(X0) + 32'(col_q) * CELL_W + 32'(px_q));
                vga_y      = 9'(32'(Y0) + 32'(row_q) * CELL_H + 32'(py_q));
                vga_colour = colour_q;
                if (clear_all) begin
                    pend_n = 1'b1;
                end
                if (px_q == CW_B'(CELL_W - 1)) begin
                    px_n = '0;
                    if (py_q == CH_B'(CELL_H - 1)) begin
                        bitmap_n[cell_idx_q] = set_q;
                        // A clear requested on the final plot still chains straight into CLEAR.
                        if (pend_q || clear_all) begin
                            state_n = CLEAR;
                            pend_n  = 1'b0;
                            cx_n    = '0;
                            cy_n    = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        py_n = py_q + CH_B'(1);
                    end
                end else begin
                    px_n = px_q + CW_B'(1);
                end
            end

            CLEAR: begin
                busy       = 1'b1;
                vga_plot   = 1'b1;
                vga_x      = 9'(32'(X0) + 32'(cx_q));
                vga_y      = 9'(32'(Y0) + 32'(cy_q));
                vga_colour = BG_COLOUR;
                if (cx_q == AX_B'(AREA_W - 1)) begin
                    cx_n = '0;
                    if (cy_q == AY_B'(AREA_H - 1)) begin
                        bitmap_n = '0;
                        state_n  = IDLE;
                    end else begin
                        cy_n = cy_q + AY_B'(1);
                    end
                end else begin
                    cx_n = cx_q + AX_B'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            colour_q <= '0;
            set_q    <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            pend_q   <= 1'b0;
            bitmap   <= '0;
        end else begin
            state_q  <= state_n;
            col_q    <= col_n;
            row_q    <= row_n;
            colour_q <= colour_n;
            set_q    <= set_n;
            px_q     <= px_n;
            py_q     <= py_n;
            cx_q     <= cx_n;
            cy_q     <= cy_n;
            pend_q   <= pend_n;
            bitmap   <= bitmap_n;
        end
    end

endmodule

// File: tb/tb_canvas_grid_painter.sv
// Bench for canvas_grid_painter: plot-queue reference model, per-cycle comparison, directed and random stimulus.
module tb_canvas_grid_painter;

    localparam int X0 = 89;
    localparam int Y0 = 33;
    localparam int CW = 5;
    localparam int CH = 5;
    localparam int GW = 28;
    localparam int GH = 28;
    localparam int NC = GW * GH;
    localparam int DRAW = 'h7fff;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [8:0]    mouse_x = '0;
    logic [8:0]    mouse_y = '0;
    logic          left_click = 1'b0;
    logic          right_click = 1'b0;
    logic          clear_all = 1'b0;
    logic [8:0]    vga_x, vga_y;
    logic [14:0]   vga_colour;
    logic          vga_plot, busy;
    logic [NC-1:0] bitmap;

    always #5 clk = ~clk;

    canvas_grid_painter dut (
        .clock      (clk),
        .reset      (reset),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .left_click (left_click),
        .right_click(right_click),
        .clear_all  (clear_all),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .bitmap     (bitmap)
    );

    // Reference model: every pending pixel write sits in a queue; the head is this cycle's plot.
    typedef struct {
        int x;
        int y;
        int c;
    } plot_t;

    plot_t         q[$];
    int            m_mode = 0;  // 0 idle, 1 cell paint, 2 wipe
    int            m_idx = 0;
    bit            m_val = 1'b0;
    bit            m_pend = 1'b0;
    bit [NC-1:0]   m_bm = '0;

    int            pass_cnt = 0;
    int            total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic check_bm(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic bit cursor_in_grid(input int mx, input int my);
        return (mx >= X0) && (mx < X0 + GW * CW) && (my >= Y0) && (my < Y0 + GH * CH);
    endfunction

    task automatic push_cell(input int col, input int row, input int c);
        for (int r = 0; r < CH; r++)
            for (int k = 0; k < CW; k++)
                q.push_back('{X0 + col * CW + k, Y0 + row * CH + r, c});
    endtask

    task automatic push_clear();
        for (int y = 0; y < GH * CH; y++)
            for (int x = 0; x < GW * CW; x++)
                q.push_back('{X0 + x, Y0 + y, 0});
    endtask

    task automatic model_step();
        int mx, my, col, row;
        bit skip;
        if (reset) begin
            q.delete();
            m_bm   = '0;
            m_pend = 1'b0;
            m_mode = 0;
        end else if (q.size() != 0) begin
            if (m_mode == 1 && clear_all) m_pend = 1'b1;
            void'(q.pop_front());
            if (q.size() == 0) begin
                if (m_mode == 1) m_bm[m_idx] = m_val;
                else m_bm = '0;
                if (m_mode == 1 && m_pend) begin
                    m_pend = 1'b0;
                    push_clear();
                    m_mode = 2;
                end else begin
                    m_mode = 0;
                end
            end
        end else if (clear_all) begin
            push_clear();
            m_mode = 2;
        end else begin
            mx = int'(mouse_x);
            my = int'(mouse_y);
            if (cursor_in_grid(mx, my) && (left_click || right_click)) begin
                col  = (mx - X0) / CW;
                row  = (my - Y0) / CH;
                skip = 1'b0;
`ifdef CANVAS_SKIP_REDUNDANT_EN
                skip = (m_bm[row * GW + col] == left_click);
`endif
                if (!skip) begin
                    m_idx  = row * GW + col;
                    m_val  = left_click;
                    m_mode = 1;
                    push_cell(col, row, left_click ? DRAW : 0);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        bit eb;
        @(negedge clk);
        eb = (q.size() != 0);
        check("busy", 32'(busy), 32'(eb));
        check("vga_plot", 32'(vga_plot), 32'(eb));
        if (eb) begin
            check("vga_x", 32'(vga_x), q[0].x);
            check("vga_y", 32'(vga_y), q[0].y);
            check("vga_colour", 32'(vga_colour), q[0].c);
        end
        check_bm("bitmap", bitmap, m_bm);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic click(input int mx, input int my, input bit l, input bit r);
        mouse_x     = 9'(mx);
        mouse_y     = 9'(my);
        left_click  = l;
        right_click = r;
        tick();
        left_click  = 1'b0;
        right_click = 1'b0;
    endtask

    task automatic observe(input int max_c, output int n, output int fx, output int fy,
                           output int fc, output int lx, output int ly);
        int i;
        n = 0; fx = -1; fy = -1; fc = -1; lx = -1; ly = -1; i = 0;
        while (busy === 1'b1 && i < max_c) begin
            if (vga_plot === 1'b1) begin
                if (n == 0) begin
                    fx = int'(vga_x); fy = int'(vga_y); fc = int'(vga_colour);
                end
                lx = int'(vga_x); ly = int'(vga_y);
                n++;
            end
            tick();
            i++;
        end
        if (i >= max_c) check("observe_timeout", 32'(busy), 32'd0);
    endtask

    task automatic expect_idle(input string name, input int mx, input int my);
        mouse_x    = 9'(mx);
        mouse_y    = 9'(my);
        left_click = 1'b1;
        repeat (3) begin
            tick();
            check(name, 32'(busy), 32'd0);
        end
        left_click = 1'b0;
    endtask

    initial begin
        int n, fx, fy, fc, lx, ly, g;
        bit pulsed, cleared;

        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_x", 32'(vga_x), 32'd0);
        check("rst_y", 32'(vga_y), 32'd0);
        check("rst_colour", 32'(vga_colour), 32'd0);
        check_bm("rst_bitmap", bitmap, '0);
        reset = 1'b0;
        tick();

        // Single paint at the grid origin
        click(89, 33, 1'b1, 1'b0);
        observe(100, n, fx, fy, fc, lx, ly);
        check("origin_plots", n, 25);
        check("origin_first_x", fx, 89);
        check("origin_first_y", fy, 33);
        check("origin_colour", fc, 'h7fff);
        check("origin_last_x", lx, 93);
        check("origin_last_y", ly, 37);
        check("origin_bit0", 32'(bitmap[0]), 32'd1);

        // Bottom-right cell and just-outside cursors
        click(228, 172, 1'b1, 1'b0);
        observe(100, n, fx, fy, fc, lx, ly);
        check("corner_first_x", fx, 224);
        check("corner_first_y", fy, 168);
        check("corner_last_x", lx, 228);
        check("corner_last_y", ly, 172);
        check("corner_bit783", 32'(bitmap[783]), 32'd1);
        expect_idle("outside_left_busy", 88, 33);
        expect_idle("outside_right_busy", 229, 40);

        // Paint wins over erase; then erase the same cell
        click(94, 33, 1'b1, 1'b1);
        observe(100, n, fx, fy, fc, lx, ly);
        check("both_plots", n, 25);
        check("both_colour", fc, 'h7fff);
        check("both_bit1", 32'(bitmap[1]), 32'd1);
        click(94, 33, 1'b0, 1'b1);
        observe(100, n, fx, fy, fc, lx, ly);
        check("erase_plots", n, 25);
        check("erase_colour", fc, 0);
        check("erase_bit1", 32'(bitmap[1]), 32'd0);

        // Clear requested on the third paint plot
        click(89, 33, 1'b1, 1'b0);
        n = 0; pulsed = 1'b0; g = 0;
        while (busy === 1'b1 && g < 30000) begin
            if (vga_plot === 1'b1) n++;
            if (n == 3 && !pulsed) begin
                clear_all = 1'b1;
                pulsed    = 1'b1;
            end
            tick();
            clear_all = 1'b0;
            g++;
        end
        check("chain_plots", n, 25 + 19600);
        check("chain_busy", 32'(busy), 32'd0);
        check_bm("chain_bitmap", bitmap, '0);

        // Reset during the tenth plot of a paint
        click(120, 60, 1'b1, 1'b0);
        observe(100, n, fx, fy, fc, lx, ly);
        check("pre_reset_bit146", 32'(bitmap[146]), 32'd1);
        click(150, 100, 1'b1, 1'b0);
        repeat (9) tick();
        check("tenth_plot", 32'(vga_plot), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_plot", 32'(vga_plot), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check_bm("abort_bitmap", bitmap, '0);
        reset = 1'b0;
        tick();

`ifdef CANVAS_SKIP_REDUNDANT_EN
        click(89, 33, 1'b1, 1'b0);
        observe(100, n, fx, fy, fc, lx, ly);
        expect_idle("redundant_busy", 89, 33);
`endif

        // Random traffic: level-held clicks, boundary cursors, occasional reset, one wipe
        cleared = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0: begin
                        mouse_x = 9'($urandom_range(0, 511));
                        mouse_y = 9'($urandom_range(0, 511));
                    end
                    1: begin
                        mouse_x = ($urandom_range(0, 1) == 0) ? 9'd88 : 9'd229;
                        mouse_y = 9'($urandom_range(30, 175));
                    end
                    2: begin
                        mouse_x = 9'($urandom_range(86, 231));
                        mouse_y = ($urandom_range(0, 1) == 0) ? 9'd32 : 9'd173;
                    end
                    default: begin
                        mouse_x = 9'(X0 + $urandom_range(0, GW * CW - 1));
                        mouse_y = 9'(Y0 + $urandom_range(0, GH * CH - 1));
                    end
                endcase
                left_click  = ($urandom_range(0, 2) == 0);
                right_click = ($urandom_range(0, 2) == 0);
            end
            clear_all = 1'b0;
            if (!cleared && $urandom_range(0, 5999) == 0) begin
                clear_all = 1'b1;
                cleared   = 1'b1;
            end
            reset = ($urandom_range(0, 2999) == 0);
            tick();
        end
        clear_all   = 1'b0;
        left_click  = 1'b0;
        right_click = 1'b0;
        reset       = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
